// File: rtl/fsram_pkg.sv
// Shared definitions for the FSRAM reader path: drain FSM encoding and default geometry.
package fsram_pkg;

  localparam int SRAM_NUM_DEF = 8;
  localparam int ADDR_W_DEF   = 12;
  localparam int CNT_W_DEF    = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/fsram_drain_buf.sv
// Two-entry FIFO holding captured SRAM words; head is visible combinationally.
// Zero-latency head, writes after push; caller guarantees no push when full and no pop when empty.
module fsram_drain_buf #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fsram_drain.sv
// Streams a block of FSRAM port-B words to a valid/ready consumer; first word 3 cycles after start.
// Reads are issued only when the 2-entry buffer can take them; FSRAM_DRAIN_CHECKSUM_EN adds an XOR checksum.
module fsram_drain
  import fsram_pkg::*;
#(
  parameter int SRAM_NUM = SRAM_NUM_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        word_cnt,
  output logic                    CENB,
  output logic [SRAM_NUM-1:0]     WENB,
  output logic [ADDR_W-1:0]       AB,
  input  logic [SRAM_NUM*16-1:0]  QB,
  output logic [SRAM_NUM*16-1:0]  dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic                    done
`ifdef FSRAM_DRAIN_CHECKSUM_EN
  ,
  output logic [SRAM_NUM*16-1:0]  checksum
`endif
);

  localparam int DW = SRAM_NUM * 16;

  drain_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  issued_q;
  logic              inflight_q;
  logic [1:0]        buf_count;
  logic [2:0]        occ;
  logic              pop;
  logic              issue;
  logic              accept;
  logic              last_issue;
  logic              last_pop;

  assign pop    = dout_valid && dout_ready;
  assign accept = (state_q == IDLE) && start;

  // Words already owed to the buffer after this cycle's pop; pop implies buf_count >= 1.
  assign occ        = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == READ) && (occ < 3'd2);
  assign last_issue = issue && ((issued_q + CNT_W'(1)) == cnt_q);
  assign last_pop   = pop && (buf_count == 2'd1) && !inflight_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (word_cnt != '0) ? READ : DONE;
        end
      end
      READ: begin
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        addr_q   <= base_addr;
        cnt_q    <= word_cnt;
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= addr_q + ADDR_W'(1);
        issued_q <= issued_q + CNT_W'(1);
      end
    end
  end

  assign CENB       = !issue;
  assign WENB       = '1;
  assign AB         = addr_q;
  assign busy       = (state_q == READ) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign dout_valid = (buf_count != 2'd0);

  // QB lands one cycle after each issue; the issue rule reserved the slot.
  fsram_drain_buf #(
    .W (DW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_dat (QB),
    .pop      (pop),
    .head_dat (dout),
    .count    (buf_count)
  );

`ifdef FSRAM_DRAIN_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum ^ dout;
    end
  end
`endif

endmodule

// File: tb/tb_fsram_drain.sv
// Bench for fsram_drain: SRAM model, random backpressure, scoreboard on reads and output words.
module tb_fsram_drain;
  import fsram_pkg::*;

  localparam int SN    = SRAM_NUM_DEF;
  localparam int AW    = ADDR_W_DEF;
  localparam int CW    = CNT_W_DEF;
  localparam int DW    = SN * 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_cnt;
  logic          CENB;
  logic [SN-1:0] WENB;
  logic [AW-1:0] AB;
  logic [DW-1:0] QB;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          busy;
  logic          done;
`ifdef FSRAM_DRAIN_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  fsram_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_cnt   (word_cnt),
    .CENB       (CENB),
    .WENB       (WENB),
    .AB         (AB),
    .QB         (QB),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
`ifdef FSRAM_DRAIN_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .done       (done)
  );

  // FSRAM port B: registered read, data one cycle after a CENB-low cycle.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!CENB) QB <= mem[AB];
  end

  int            vectors = 0;
  int            errors = 0;
  int            cyc = 0;
  int            xfer_cnt = 0;
  int            first_vld_cyc = -1;
  int            last_xfer_cyc = 0;
  int            outstanding = 0;
  int            pop_now = 0;
  int            ready_mode = 0;
  int            phase = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_dout = '0;
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] addr_q [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Consumer: always ready, 1,0,0,1 pattern, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = (phase % 4 == 0) || (phase % 4 == 3);
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
    phase++;
  end

  // Monitor: every read address and every transferred word comes off the expectation queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      pop_now = (dout_valid && dout_ready) ? 1 : 0;
      if (stall_prev) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_dout", dout, prev_dout);
      end
      if (!CENB) begin
        if (addr_q.size() == 0) fail("extra_read");
        else chk("read_addr", AB, addr_q.pop_front());
        chk("issue_room", (outstanding - pop_now) <= 1, 1);
        chk("wenb", WENB, {SN{1'b1}});
        outstanding++;
      end
      if (dout_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (pop_now != 0) begin
        if (exp_q.size() == 0) fail("extra_word");
        else chk("dout", dout, exp_q.pop_front());
        last_xfer_cyc = cyc;
        xfer_cnt++;
        outstanding--;
      end
      stall_prev = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
  end

  task automatic push_expect(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(mem[(base + i) % DEPTH]);
      addr_q.push_back(AW'((base + i) % DEPTH));
    end
  endtask

  task automatic reset_checks();
    chk("rst_cenb", CENB, 1);
    chk("rst_wenb", WENB, {SN{1'b1}});
    chk("rst_ab", AB, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef FSRAM_DRAIN_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
  endtask

  // One transfer; glitch > 0 pulses a stray start that many cycles in.
  task automatic run(input int base, input int cnt, input int mode, input int glitch);
    int s;
    int done_cyc;
    bit got;
    bit busy_at_done;
    @(posedge clk); #1;
    ready_mode = mode;
    push_expect(base, cnt);
    start         = 1'b1;
    base_addr     = AW'(base);
    word_cnt      = CW'(cnt);
    s             = cyc;
    first_vld_cyc = -1;
    got           = 1'b0;
    done_cyc      = 0;
    busy_at_done  = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(posedge clk); #1;
      start = (k == glitch);
      if (start) begin
        base_addr = AW'($urandom);
        word_cnt  = CW'($urandom_range(0, 8));
      end
      if (k == 0) chk("busy_after_start", busy, cnt != 0);
      @(negedge clk);
      if (done) begin
        got          = 1'b1;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (!got) begin
      fail("done_timeout");
    end else begin
      chk("busy_at_done", busy_at_done, 0);
      if (cnt == 0) chk("done_cycle", done_cyc, s + 1);
      else chk("done_cycle", done_cyc, last_xfer_cyc + 1);
      if (cnt != 0) chk("first_valid_cycle", first_vld_cyc, s + 3);
      if (cnt != 0 && mode == 0) chk("last_xfer_cycle", last_xfer_cyc, s + 2 + cnt);
      chk("words_left", exp_q.size(), 0);
      chk("reads_left", addr_q.size(), 0);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int x0;
    rst_n     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    word_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    mem[256] = DW'(1);
    mem[257] = DW'(2);
    mem[258] = DW'(4);
    mem[259] = DW'(8);

    #2 rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(0, 16, 0, -1);          // basic, full rate
    run(0, 16, 1, -1);          // 1,0,0,1 backpressure
    run(12'hFFE, 4, 2, -1);     // address wrap
    run(0, 0, 0, -1);           // zero length
    run(0, 16, 2, 6);           // stray start mid-transfer

    // Abort after 5 of 16 words, then a fresh short transfer.
    @(posedge clk); #1;
    ready_mode = 0;
    push_expect(0, 16);
    x0        = xfer_cnt;
    start     = 1'b1;
    base_addr = '0;
    word_cnt  = CW'(16);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && (xfer_cnt - x0) < 5; k++) @(posedge clk);
    if ((xfer_cnt - x0) < 5) fail("abort_wait_timeout");
    #3 rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(32, 2, 0, -1);

`ifdef FSRAM_DRAIN_CHECKSUM_EN
    run(256, 4, 1, -1);
    chk("checksum", checksum, DW'(15));
`endif

    for (int t = 0; t < 12; t++) begin
      run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
          int'($urandom_range(0, 2)), int'($urandom_range(1, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
